// File: rtl/clint_ctrl_pkg.sv
// clint_ctrl_pkg: shared cause codes, mstatus bit positions and trap FSM encoding
package clint_ctrl_pkg;
  localparam logic [63:0] MCAUSE_ECALL = 64'd11;
  localparam logic [63:0] MCAUSE_MTI = 64'h8000_0000_0000_0007;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI = 12;
  localparam int MPP_LO = 11;
  typedef enum logic [2:0] {IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT} state_t;
endpackage

// File: rtl/clint_ctrl_mstatus_upd.sv
// clint_mstatus_upd: combinational mstatus transform for trap entry (ret=0) and mret (ret=1)
module clint_mstatus_upd
  import clint_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            ret,
  input  logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] upd
);
  always_comb begin
    upd = mstatus;
    upd[MIE_BIT] = ret ? mstatus[MPIE_BIT] : 1'b0;
    upd[MPIE_BIT] = ret ? 1'b1 : mstatus[MIE_BIT];
    upd[MPP_HI:MPP_LO] = 2'b11;
  end
endmodule

// File: rtl/clint_ctrl.sv
// clint_ctrl: M-mode trap sequencer issuing mepc/mcause/mstatus writes then a redirect (CLINT_VECTORED_EN enables vectored interrupts)
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL = XLEN'(MCAUSE_ECALL),
  parameter logic [XLEN-1:0] CAUSE_MTI = XLEN'(MCAUSE_MTI)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] commit_next_pc_i,
  input  logic            commit_ecall_i,
  input  logic            commit_mret_i,
  input  logic            cpu_csr_wen_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic            global_int_en_i,
  input  logic            mtime_int_en_i,
  input  logic            mtime_int_pend_i,
  output logic            clint_mepc_wen_o,
  output logic [XLEN-1:0] clint_mepc_wdata_o,
  output logic            clint_mcause_wen_o,
  output logic [XLEN-1:0] clint_mcause_wdata_o,
  output logic            clint_mstatus_wen_o,
  output logic [XLEN-1:0] clint_mstatus_wdata_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);
  state_t state;
  logic [XLEN-1:0] epc, cause, mst, ret_pc, mst_upd, base, target;
  logic is_ret, is_int, irq, accept, take_ret;
  assign irq = global_int_en_i && mtime_int_en_i && mtime_int_pend_i;
  assign take_ret = !commit_ecall_i && commit_mret_i;
  assign accept = !rst && state == IDLE && commit_valid_i && (commit_ecall_i || commit_mret_i || irq);
  clint_mstatus_upd #(.XLEN(XLEN)) u_upd (
    .ret    (take_ret),
    .mstatus(csr_mstatus_i),
    .upd    (mst_upd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc <= '0;
      cause <= '0;
      mst <= '0;
      ret_pc <= '0;
      is_ret <= 1'b0;
      is_int <= 1'b0;
    end else if (accept) begin
      state <= take_ret ? WR_MSTATUS : WR_MEPC;
      epc <= commit_ecall_i ? commit_pc_i : commit_next_pc_i;
      cause <= commit_ecall_i ? CAUSE_ECALL : CAUSE_MTI;
      mst <= mst_upd;
      ret_pc <= csr_mepc_i;
      is_ret <= take_ret;
      is_int <= !commit_ecall_i && !commit_mret_i;
    end else if (state != IDLE && !(cpu_csr_wen_i && state != REDIRECT)) begin
      state <= state == WR_MEPC ? WR_MCAUSE :
               state == WR_MCAUSE ? WR_MSTATUS :
               state == WR_MSTATUS ? REDIRECT : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && commit_valid_i) assert (!(commit_ecall_i && commit_mret_i));
  end
  assign base = {csr_mtvec_i[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
  assign target = base + ((is_int && csr_mtvec_i[1:0] == 2'b01) ? {cause[XLEN-3:0], 2'b00} : '0);
`else
  logic unused_mode;
  assign unused_mode = ^{is_int, csr_mtvec_i[1:0]};
  assign target = base;
`endif
  assign clint_mepc_wen_o = state == WR_MEPC;
  assign clint_mepc_wdata_o = clint_mepc_wen_o ? epc : '0;
  assign clint_mcause_wen_o = state == WR_MCAUSE;
  assign clint_mcause_wdata_o = clint_mcause_wen_o ? cause : '0;
  assign clint_mstatus_wen_o = state == WR_MSTATUS;
  assign clint_mstatus_wdata_o = clint_mstatus_wen_o ? mst : '0;
  assign redirect_valid_o = state == REDIRECT;
  assign redirect_pc_o = redirect_valid_o ? (is_ret ? ret_pc : target) : '0;
  assign stall_o = state != IDLE || accept;
endmodule
